record_framer: RTL
==================

RECORD_FRAMER -- requirements
Module: record_framer

Interface
REQ-001 SHALL have parameter DW, default 48: record width in bits, a multiple of 8, range 16..64.
REQ-002 SHALL have parameter SOF, default 8'h7E: start-of-frame byte.
REQ-003 SHALL have parameter ESC, default 8'h7D: escape byte.
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port read_empty  input  1  ring buffer holds no record.
REQ-007 SHALL have port read_clock_enable  output  1  one-cycle pop strobe to the ring buffer.
REQ-008 SHALL have port read_data  input  DW  record; valid the cycle after a pop.
REQ-009 SHALL have port uart_ready  input  1  serial transmitter can accept a byte.
REQ-010 SHALL have port uart_clock_enable  output  1  one-cycle byte-load strobe.
REQ-011 SHALL have port uart_data  output  8  byte presented with uart_clock_enable.
REQ-012 SHALL have port busy  output  1  a frame is in progress.

Function
REQ-013 SHALL use states IDLE, POP, LATCH, SEND, ESC2, CSUM, GAP.
REQ-014 IDLE SHALL move to POP when read_empty=0; it SHALL stay in IDLE otherwise.
REQ-015 POP SHALL assert read_clock_enable for exactly one cycle, then enter LATCH.
REQ-016 LATCH SHALL capture read_data into a shift register, clear the checksum, load the SOF byte as pending, and enter SEND.
REQ-017 A byte SHALL be emitted only in a cycle where uart_ready=1, with uart_clock_enable=1 and uart_data=byte; GAP SHALL follow every emission.
REQ-018 GAP SHALL last exactly one cycle with uart_clock_enable=0, to absorb uart_ready deassertion latency.
REQ-019 Payload SHALL be sent MSB byte first (read_data[DW-1:DW-8] first), DW/8 bytes in total.
REQ-020 A payload byte equal to SOF or ESC SHALL be sent as ESC followed by (byte XOR 8'h20), using ESC2 for the second byte.
REQ-021 The SOF byte itself SHALL never be escaped.
REQ-022 The checksum SHALL be the XOR of the unescaped payload bytes.
REQ-023 Once the last byte (payload or checksum) is emitted, the block SHALL return to IDLE after GAP; the next record SHALL be popped no earlier than the following cycle.
REQ-024 The block SHALL pop exactly one record per frame and SHALL never pop while busy.
REQ-025 While uart_ready=0, the block SHALL hold state and uart_data, and no byte SHALL be lost or duplicated.
REQ-026 busy SHALL be 1 in all states except IDLE.
REQ-027 A read_empty rise during a frame SHALL have no effect on that frame.

Reset
REQ-028 While reset=0, state SHALL be IDLE, and read_clock_enable, uart_clock_enable, uart_data, busy, the checksum and the shift register SHALL all be 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame, with no further bytes emitted; the first frame after reset release SHALL begin with SOF.

Configuration
REQ-030 With RECORD_FRAMER_CHECKSUM_EN defined, the block SHALL enter CSUM after the last payload byte and send the checksum, escaped per REQ-020.
REQ-031 Without RECORD_FRAMER_CHECKSUM_EN, the block SHALL omit CSUM and the checksum register, and the frame SHALL end after the last payload byte.

Structure
REQ-032 The state typedef and the default SOF/ESC/XOR-mask constants SHALL live in package lpc_sniffer_pkg.
REQ-033 Escape decision and escaped-byte generation SHALL be a combinational sub-module frame_escaper (in: byte; out: needs_escape, escaped_byte).

Verification
REQ-034 Record 48'h0000_0080_3402 with uart_ready=1 SHALL produce bytes 7E 00 00 00 80 34 02, followed by B6 when the checksum macro is defined.
REQ-035 Record 48'h7E7D_0000_0001 SHALL produce 7E 7D 5E 7D 5D 00 00 00 01, followed by 02 when the checksum macro is defined.
REQ-036 With read_empty=1 for 100 cycles, read_clock_enable, uart_clock_enable and busy SHALL stay 0.
REQ-037 With uart_ready low for 20 cycles after the third byte, the remaining bytes SHALL resume in order with none dropped or repeated.
REQ-038 Two queued records SHALL produce two complete frames, exactly two read_clock_enable pulses, and busy=0 for at least one cycle between the frames.
REQ-039 Reset pulsed after the fourth byte SHALL force all outputs to 0 immediately, and the next frame SHALL start with 7E.

Source files
------------

// File: rtl/lpc_sniffer_pkg.sv
// Shared types and default framing constants for record_framer and frame_escaper.
package lpc_sniffer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        ESC2  = 3'd4,
        CSUM  = 3'd5,
        GAP   = 3'd6
    } state_t;

    localparam logic [7:0] SOF_BYTE     = 8'h7E;
    localparam logic [7:0] ESC_BYTE     = 8'h7D;
    localparam logic [7:0] ESC_XOR_MASK = 8'h20;

endpackage

// File: rtl/frame_escaper.sv
// Combinational escape decision: flags bytes that collide with SOF/ESC and
// produces their XOR-masked substitute.
module frame_escaper
    import lpc_sniffer_pkg::*;
#(
    parameter logic [7:0] SOF = SOF_BYTE,
    parameter logic [7:0] ESC = ESC_BYTE
) (
    input  logic [7:0] in_byte,
    output logic       needs_escape,
    output logic [7:0] escaped_byte
);

    assign needs_escape = (in_byte == SOF) || (in_byte == ESC);
    assign escaped_byte = in_byte ^ ESC_XOR_MASK;

endmodule

// File: rtl/record_framer.sv
// Pops one record from a ring buffer and sends it as an SOF-delimited, byte-stuffed
// UART frame. Define RECORD_FRAMER_CHECKSUM_EN to append an XOR checksum byte.
//
// Handshake: read_clock_enable is a one-cycle pop, read_data is sampled the cycle
// after; a byte is transferred in any cycle with uart_clock_enable=1, which only
// happens while uart_ready=1, and every transfer is followed by one GAP cycle.
module record_framer
    import lpc_sniffer_pkg::*;
#(
    parameter int         DW  = 48,
    parameter logic [7:0] SOF = SOF_BYTE,
    parameter logic [7:0] ESC = ESC_BYTE
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          read_empty,
    output logic          read_clock_enable,
    input  logic [DW-1:0] read_data,
    input  logic          uart_ready,
    output logic          uart_clock_enable,
    output logic [7:0]    uart_data,
    output logic          busy,
    output logic [2:0]    fsm_state
);

    localparam logic [3:0] NB = 4'(DW / 8);

    state_t        state;
    logic [DW-1:0] shift;
    logic [3:0]    remaining;
    logic          esc_pending;
    logic [7:0]    esc_hold;
    logic [7:0]    next_byte;
    logic          need_esc;
    logic [7:0]    escaped;

`ifdef RECORD_FRAMER_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_sent;

    assign next_byte = (remaining != 4'd0) ? shift[DW-1 -: 8] : csum;
`else
    assign next_byte = shift[DW-1 -: 8];
`endif

    frame_escaper #(
        .SOF(SOF),
        .ESC(ESC)
    ) u_escaper (
        .in_byte     (next_byte),
        .needs_escape(need_esc),
        .escaped_byte(escaped)
    );

    // Byte in uart_data is already the wire byte; the escaped half waits in esc_hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shift       <= '0;
            remaining   <= 4'd0;
            esc_pending <= 1'b0;
            esc_hold    <= 8'h00;
            uart_data   <= 8'h00;
`ifdef RECORD_FRAMER_CHECKSUM_EN
            csum        <= 8'h00;
            csum_sent   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!read_empty) state <= POP;
                end
                POP: begin
                    state <= LATCH;
                end
                LATCH: begin
                    shift       <= read_data;
                    remaining   <= NB;
                    uart_data   <= SOF;
                    esc_pending <= 1'b0;
`ifdef RECORD_FRAMER_CHECKSUM_EN
                    csum        <= 8'h00;
                    csum_sent   <= 1'b0;
`endif
                    state       <= SEND;
                end
                SEND, ESC2, CSUM: begin
                    if (uart_ready) state <= GAP;
                end
                GAP: begin
                    if (esc_pending) begin
                        esc_pending <= 1'b0;
                        uart_data   <= esc_hold;
                        state       <= ESC2;
                    end else if (remaining != 4'd0) begin
                        shift       <= {shift[DW-9:0], 8'h00};
                        remaining   <= remaining - 4'd1;
                        uart_data   <= need_esc ? ESC : next_byte;
                        esc_pending <= need_esc;
                        esc_hold    <= escaped;
`ifdef RECORD_FRAMER_CHECKSUM_EN
                        csum        <= csum ^ next_byte;
`endif
                        state       <= SEND;
                    end
`ifdef RECORD_FRAMER_CHECKSUM_EN
                    else if (!csum_sent) begin
                        csum_sent   <= 1'b1;
                        uart_data   <= need_esc ? ESC : next_byte;
                        esc_pending <= need_esc;
                        esc_hold    <= escaped;
                        state       <= CSUM;
                    end
`endif
                    else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign read_clock_enable = (state == POP);
    assign uart_clock_enable = uart_ready && ((state == SEND) || (state == ESC2) || (state == CSUM));
    assign busy              = (state != IDLE);
    assign fsm_state         = state;

endmodule
